// File: rtl/bitmask_serializer_7b_if.sv
// Handshake bundle for the bit-mask serializer.
// Mask input channel plus index output channel.
interface bitmask_serializer_7b_if;
    logic       in_val;
    logic       in_rdy;
    logic [6:0] in_mask;
    logic       in_sign;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] out_idx;
    logic       out_sign;
    logic       out_last;
    logic       out_zero;
    logic [2:0] out_beat;

    modport master (
        output in_val, in_mask, in_sign, out_rdy,
        input  in_rdy, out_val, out_idx, out_sign,
        input  out_last, out_zero, out_beat
    );

    modport slave (
        input  in_val, in_mask, in_sign, out_rdy,
        output in_rdy, out_val, out_idx, out_sign,
        output out_last, out_zero, out_beat
    );
endinterface

// File: rtl/bitmask_serializer_7b.sv
// Serializes a 7-bit essential-bit mask into
// bit-position indices, highest set bit first.
module bitmask_serializer_7b #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic clk,
    input  logic reset,
    bitmask_serializer_7b_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_r, state_n;
    logic [6:0] mask_r, mask_n;
    logic       sign_r, sign_n;
    logic       zero_r, zero_n;
    logic [2:0] beat_r, beat_n;

    logic [2:0] hi_idx;
    logic       onehot;
    logic       last;
    logic       scan;
    logic       fire;
    logic       rdy;
    logic       load;

    // Highest-set-bit priority encoder over the held mask
    always_comb begin
        hi_idx = 3'd0;
        priority case (1'b1)
            mask_r[6]: hi_idx = 3'd6;
            mask_r[5]: hi_idx = 3'd5;
            mask_r[4]: hi_idx = 3'd4;
            mask_r[3]: hi_idx = 3'd3;
            mask_r[2]: hi_idx = 3'd2;
            mask_r[1]: hi_idx = 3'd1;
            mask_r[0]: hi_idx = 3'd0;
            default:   hi_idx = 3'd0;
        endcase
    end

    assign onehot = (mask_r != 7'd0) &&
                    ((mask_r & (mask_r - 7'd1)) == 7'd0);
    assign last   = zero_r | onehot;
    assign scan   = (state_r == SCAN) & ~reset;
    assign fire   = scan & bus.out_rdy;
    assign rdy    = ~reset &
                    ((state_r == IDLE) | (fire & last));
    assign load   = bus.in_val & rdy;

    assign bus.in_rdy   = rdy;
    assign bus.out_val  = scan;
    assign bus.out_idx  = (scan & ~zero_r) ? hi_idx : 3'd0;
    assign bus.out_sign = scan & sign_r;
    assign bus.out_last = scan & last;
    assign bus.out_zero = scan & zero_r;
    assign bus.out_beat = scan ? beat_r : 3'd0;

    // Next-state: load new mask, step to next bit, or retire
    always_comb begin
        state_n = state_r;
        mask_n  = mask_r;
        sign_n  = sign_r;
        zero_n  = zero_r;
        beat_n  = beat_r;
        if (fire && !last) begin
            mask_n = mask_r & ~(7'd1 << hi_idx);
            beat_n = beat_r + 3'd1;
        end else if (load) begin
            mask_n = bus.in_mask;
            sign_n = bus.in_sign;
            beat_n = 3'd0;
            zero_n = 1'b0;
            if (bus.in_mask != 7'd0) begin
                state_n = SCAN;
            end else if (!SKIP_ZERO) begin
                state_n = SCAN;
                zero_n  = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end else if (fire) begin
            state_n = IDLE;
            mask_n  = 7'd0;
            zero_n  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mask_r  <= 7'd0;
            sign_r  <= 1'b0;
            zero_r  <= 1'b0;
            beat_r  <= 3'd0;
        end else begin
            state_r <= state_n;
            mask_r  <= mask_n;
            sign_r  <= sign_n;
            zero_r  <= zero_n;
            beat_r  <= beat_n;
        end
    end

endmodule

// File: tb/tb_bitmask_serializer_7b.sv
// Scoreboard bench for bitmask_serializer_7b.
// Two instances: zero-mask beat and zero-mask skip.
module tb_bitmask_serializer_7b;

    typedef struct packed {
        logic [2:0] idx;
        logic       sign;
        logic       last;
        logic       zero;
        logic [2:0] beat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   rnd_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    bitmask_serializer_7b_if b0 ();
    bitmask_serializer_7b_if b1 ();

    bitmask_serializer_7b #(.SKIP_ZERO(1'b0)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );
    bitmask_serializer_7b #(.SKIP_ZERO(1'b1)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int idx, input logic s,
                                input logic l, input logic z,
                                input int beat);
        exp_t e;
        e.idx  = 3'(idx);
        e.sign = s;
        e.last = l;
        e.zero = z;
        e.beat = 3'(beat);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected beats for one mask on the SKIP_ZERO=0 instance
    task automatic push_model(input logic [6:0] m, input logic s);
        int pc;
        int n;
        pc = $countones(m);
        n = 0;
        if (m == 7'd0) begin
            q0.push_back(mk(0, s, 1'b1, 1'b1, 0));
        end else begin
            for (int i = 6; i >= 0; i--) begin
                if (m[i]) begin
                    q0.push_back(mk(i, s, (n == pc - 1), 1'b0, n));
                    n++;
                end
            end
        end
    endtask

    // Called just after a posedge; returns just after the accept edge
    task automatic send0(input logic [6:0] m, input logic s,
                         output int waited);
        b0.in_val = 1'b1;
        b0.in_mask = m;
        b0.in_sign = s;
        waited = 0;
        forever begin
            @(negedge clk);
            if (b0.in_rdy) break;
            waited++;
            if (waited > 200) begin
                chk("send0_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        b0.in_val = 1'b0;
    endtask

    task automatic send1(input logic [6:0] m, input logic s,
                         output int waited);
        b1.in_val = 1'b1;
        b1.in_mask = m;
        b1.in_sign = s;
        waited = 0;
        forever begin
            @(negedge clk);
            if (b1.in_rdy) break;
            waited++;
            if (waited > 200) begin
                chk("send1_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        b1.in_val = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 &&
               n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (which == 0)
            chk("drain_q0", 32'(q0.size()), 32'd0);
        else
            chk("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    // Monitor for the SKIP_ZERO=0 instance
    always @(negedge clk) begin : mon0
        exp_t e;
        exp_t a;
        if (!reset && b0.out_val && b0.out_rdy) begin
            a = {b0.out_idx, b0.out_sign, b0.out_last,
                 b0.out_zero, b0.out_beat};
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_beat: got %h expected none",
                         a);
            end else begin
                e = q0.pop_front();
                chk("u0_beat", 32'(a), 32'(e));
            end
        end
    end

    // Monitor for the SKIP_ZERO=1 instance
    always @(negedge clk) begin : mon1
        exp_t e;
        exp_t a;
        if (!reset && b1.out_val && b1.out_rdy) begin
            a = {b1.out_idx, b1.out_sign, b1.out_last,
                 b1.out_zero, b1.out_beat};
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_beat: got %h expected none",
                         a);
            end else begin
                e = q1.pop_front();
                chk("u1_beat", 32'(a), 32'(e));
            end
        end
    end

    // Random downstream backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) b0.out_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [6:0] m;
        logic s;
        b0.in_val = 1'b0;
        b0.in_mask = 7'd0;
        b0.in_sign = 1'b0;
        b0.out_rdy = 1'b1;
        b1.in_val = 1'b0;
        b1.in_mask = 7'd0;
        b1.in_sign = 1'b0;
        b1.out_rdy = 1'b1;

        @(negedge clk);
        chk("reset_outs",
            32'({b0.out_val, b0.in_rdy, b0.out_idx, b0.out_sign,
                 b0.out_last, b0.out_zero, b0.out_beat}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", 32'({b0.in_rdy, b1.in_rdy}), 32'd3);
        @(posedge clk);
        #1;

        q0.push_back(mk(6, 1'b1, 1'b0, 1'b0, 0));
        q0.push_back(mk(4, 1'b1, 1'b0, 1'b0, 1));
        q0.push_back(mk(1, 1'b1, 1'b1, 1'b0, 2));
        send0(7'b1010010, 1'b1, w);
        drain(0);

        q0.push_back(mk(0, 1'b0, 1'b1, 1'b0, 0));
        send0(7'b0000001, 1'b0, w);
        push_model(7'b1111111, 1'b1);
        send0(7'b1111111, 1'b1, w);
        chk("b2b_accept_wait", 32'(w), 32'd0);
        drain(0);

        q0.push_back(mk(0, 1'b1, 1'b1, 1'b1, 0));
        send0(7'b0000000, 1'b1, w);
        drain(0);

        q1.push_back(mk(3, 1'b0, 1'b1, 1'b0, 0));
        send1(7'b0000000, 1'b1, w);
        send1(7'b0001000, 1'b0, w);
        chk("skip_accept_wait", 32'(w), 32'd0);
        drain(1);

        b0.out_rdy = 1'b0;
        q0.push_back(mk(5, 1'b0, 1'b0, 1'b0, 0));
        q0.push_back(mk(4, 1'b0, 1'b1, 1'b0, 1));
        send0(7'b0110000, 1'b0, w);
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold",
                32'({b0.out_val, b0.out_idx, b0.out_beat, b0.in_rdy}),
                32'({1'b1, 3'd5, 3'd0, 1'b0}));
        end
        @(posedge clk);
        #1;
        b0.out_rdy = 1'b1;
        drain(0);

        q0.push_back(mk(6, 1'b1, 1'b0, 1'b0, 0));
        send0(7'b1110000, 1'b1, w);
        @(posedge clk);
        #1;
        b0.out_rdy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("in_reset_outs", 32'({b0.out_val, b0.in_rdy}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0.out_rdy = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", 32'({b0.out_val, b0.in_rdy}),
            32'({1'b0, 1'b1}));
        @(posedge clk);
        #1;
        drain(0);

        rnd_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            m = 7'($urandom);
            if (k == 5) m = 7'd0;
            s = 1'($urandom_range(0, 1));
            push_model(m, s);
            send0(m, s, w);
        end
        drain(0);
        rnd_en = 1'b0;
        b0.out_rdy = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
